// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared constants, state encoding and Rcon helper for the AES-128 key-schedule sequencer.
package aes_key_sched_ctrl_pkg;
  localparam int KEY_LEN     = 128;
  localparam int WORD_LEN    = 32;
  localparam int NR          = 10;
  localparam int GEN_TIMEOUT = 15;
  localparam int IDX_W       = 4;
  localparam int TMR_W       = 5;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_rk_store.sv
// Round-key store: (NR+1) x KEY_LEN registers, one write port, one registered read port.
module aes_rk_store
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_waddr,
  input  logic [KEY_LEN-1:0] i_wdata,
  input  logic               i_rd_en,
  input  logic [IDX_W-1:0]   i_rd_addr,
  output logic [KEY_LEN-1:0] o_rd_data
);
  logic [KEY_LEN-1:0] r_mem [NR+1];
  logic [KEY_LEN-1:0] r_rd_data;

  // Read samples the pre-write contents, so a same-entry read/write returns the old key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= NR; i++) r_mem[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_we && (i_waddr <= IDX_W'(NR))) r_mem[i_waddr] <= i_wdata;
      if (i_rd_en) r_rd_data <= (i_rd_addr <= IDX_W'(NR)) ? r_mem[i_rd_addr] : '0;
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: drives an external single-round generator and
// collects round keys 0..NR into the round-key store.
//   state | meaning
//   IDLE  | waiting for start; stores key_in as round key 0
//   ISSUE | one-cycle request to the generator for the current round
//   WAIT  | waiting for the generator result, watchdog running
//   DONE  | one-cycle completion pulse
module aes_key_sched_ctrl
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [KEY_LEN-1:0]  i_key_in,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic                o_rk_valid,
  output logic [IDX_W-1:0]    o_rk_idx,
  output logic [KEY_LEN-1:0]  o_rk_data,
  input  logic                i_rd_en,
  input  logic [IDX_W-1:0]    i_rd_addr,
  output logic [KEY_LEN-1:0]  o_rd_data,
  output logic                o_gen_valid_in,
  output logic [KEY_LEN-1:0]  o_gen_data_in,
  output logic [WORD_LEN-1:0] o_gen_rcon,
  output logic                o_gen_opcode,
  input  logic                i_gen_valid_out,
  input  logic [KEY_LEN-1:0]  i_gen_data_out
);
  state_t              r_state;
  logic [IDX_W-1:0]    r_round;
  logic [7:0]          r_rcon;
  logic [TMR_W-1:0]    r_timer;
  logic                r_busy, r_done, r_err, r_rk_valid, r_gen_valid_in, r_gen_opcode;
  logic [IDX_W-1:0]    r_rk_idx;
  logic [KEY_LEN-1:0]  r_rk_data, r_gen_data_in;
  logic [WORD_LEN-1:0] r_gen_rcon;

  logic                w_st_we;
  logic [IDX_W-1:0]    w_st_waddr;
  logic [KEY_LEN-1:0]  w_st_wdata;

  always_comb begin
    w_st_we    = 1'b0;
    w_st_waddr = '0;
    w_st_wdata = i_key_in;
    if (r_state == ST_IDLE && i_start) begin
      w_st_we = 1'b1;
    end else if (r_state == ST_WAIT && i_gen_valid_out) begin
      w_st_we    = 1'b1;
      w_st_waddr = r_round;
      w_st_wdata = i_gen_data_out;
    end
  end

  // r_rk_data always holds store[round-1] when ISSUE runs, so it feeds the generator directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_round        <= '0;
      r_rcon         <= RCON_INIT;
      r_timer        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_rk_valid     <= 1'b0;
      r_rk_idx       <= '0;
      r_rk_data      <= '0;
      r_gen_valid_in <= 1'b0;
      r_gen_data_in  <= '0;
      r_gen_rcon     <= '0;
      r_gen_opcode   <= 1'b0;
    end else begin
      r_rk_valid     <= 1'b0;
      r_done         <= 1'b0;
      r_gen_valid_in <= 1'b0;
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_rk_valid <= 1'b1;
          r_rk_idx   <= '0;
          r_rk_data  <= i_key_in;
          r_busy     <= 1'b1;
          r_err      <= 1'b0;
          r_round    <= IDX_W'(1);
          r_rcon     <= RCON_INIT;
          r_state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_gen_valid_in <= 1'b1;
          r_gen_data_in  <= r_rk_data;
          r_gen_rcon     <= {r_rcon, {(WORD_LEN-8){1'b0}}};
          r_gen_opcode   <= 1'b0;
          r_timer        <= '0;
          r_state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_gen_valid_out) begin
            r_rk_valid <= 1'b1;
            r_rk_idx   <= r_round;
            r_rk_data  <= i_gen_data_out;
            r_rcon     <= xtime(r_rcon);
            if (r_round == IDX_W'(NR)) begin
              r_state <= ST_DONE;
            end else begin
              r_round <= r_round + 1'b1;
              r_state <= ST_ISSUE;
            end
          end else if (r_timer == TMR_W'(GEN_TIMEOUT-1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  aes_rk_store u_store (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_st_we),
    .i_waddr   (w_st_waddr),
    .i_wdata   (w_st_wdata),
    .i_rd_en   (i_rd_en),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_rk_valid     = r_rk_valid;
  assign o_rk_idx       = r_rk_idx;
  assign o_rk_data      = r_rk_data;
  assign o_gen_valid_in = r_gen_valid_in;
  assign o_gen_data_in  = r_gen_data_in;
  assign o_gen_rcon     = r_gen_rcon;
  assign o_gen_opcode   = r_gen_opcode;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 generator plus FIPS-197 key-expansion model.
module tb_aes_key_sched_ctrl;
  import aes_key_sched_ctrl_pkg::*;

  localparam logic [2047:0] SBOX_BITS = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0, reset = 1'b0, i_start = 1'b0, i_rd_en = 1'b0, i_gen_valid_out = 1'b0;
  logic [127:0] i_key_in = '0, i_gen_data_out = '0;
  logic [3:0]   i_rd_addr = '0;
  logic         o_busy, o_done, o_err, o_rk_valid, o_gen_valid_in, o_gen_opcode;
  logic [3:0]   o_rk_idx;
  logic [127:0] o_rk_data, o_rd_data, o_gen_data_in;
  logic [31:0]  o_gen_rcon;

  int n_checks = 0, n_pass = 0;
  int gen_lat = 0, gen_max_round = NR;
  bit stray_mode = 1'b0;
  int cyc = 0, issue_cyc = 0, done_cnt = 0, mon_unstable = 0, gen_cnt = -1;
  logic busy_at_done = 1'b0, holding = 1'b0;
  logic [160:0] held = '0;
  logic [127:0] gen_pend = '0;
  logic [131:0] rk_q[$];
  logic [31:0]  rcon_q[$];
  logic         op_q[$];

  aes_key_sched_ctrl dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_key_in(i_key_in),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rk_valid(o_rk_valid),
    .o_rk_idx(o_rk_idx), .o_rk_data(o_rk_data), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_gen_valid_in(o_gen_valid_in), .o_gen_data_in(o_gen_data_in),
    .o_gen_rcon(o_gen_rcon), .o_gen_opcode(o_gen_opcode),
    .i_gen_valid_out(i_gen_valid_out), .i_gen_data_out(i_gen_data_out));

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX_BITS;
    return t[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_ref(input int r);
    case (r)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;  5: return 8'h10;
      6: return 8'h20;  7: return 8'h40;  8: return 8'h80;  9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int rcon_round(input logic [7:0] b);
    for (int i = 1; i <= NR; i++) if (rcon_ref(i) == b) return i;
    return 99;
  endfunction

  // One round of AES-128 key expansion, as the external generator computes it.
  function automatic logic [127:0] ref_next(input logic [127:0] p, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    t  = sub_word({p[23:0], p[31:24]}) ^ {rc, 24'h0};
    w0 = p[127:96] ^ t;
    w1 = p[95:64] ^ w0;
    w2 = p[63:32] ^ w1;
    w3 = p[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Full FIPS-197 word expansion w[0..43]; round key r is words 4r..4r+3.
  function automatic logic [127:0] ref_rk(input logic [127:0] key, input int r);
    logic [31:0] w[44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_ref(i/4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Generator model and passive monitors.
  always @(negedge clk) begin
    cyc++;
    i_gen_valid_out = 1'b0;
    if (!reset) begin
      gen_cnt = -1;
      holding = 1'b0;
    end else begin
      if (holding && ({o_gen_data_in, o_gen_rcon, o_gen_opcode} !== held)) mon_unstable++;
      if (o_gen_valid_in) begin
        rcon_q.push_back(o_gen_rcon);
        op_q.push_back(o_gen_opcode);
        issue_cyc = cyc;
        held = {o_gen_data_in, o_gen_rcon, o_gen_opcode};
        holding = 1'b1;
        if (rcon_round(o_gen_rcon[31:24]) <= gen_max_round) begin
          gen_pend = ref_next(o_gen_data_in, o_gen_rcon[31:24]);
          gen_cnt = gen_lat;
        end
      end else if (gen_cnt > 0) gen_cnt--;
      if (gen_cnt == 0) begin
        i_gen_valid_out = 1'b1;
        i_gen_data_out = gen_pend;
        gen_cnt = -1;
      end
      if (stray_mode && o_rk_valid && (o_rk_idx < 4'(NR))) begin
        i_gen_valid_out = 1'b1;
        i_gen_data_out = {$urandom, $urandom, $urandom, $urandom};
      end
      if (o_rk_valid) begin
        rk_q.push_back({o_rk_idx, o_rk_data});
        holding = 1'b0;
      end
      if (o_done) begin
        done_cnt++;
        busy_at_done = o_busy;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [127:0] exp, input string nm);
    i_rd_en = 1'b1;
    i_rd_addr = a;
    tick();
    i_rd_en = 1'b0;
    i_rd_addr = 4'($urandom);
    n_checks++;
    if (o_rd_data !== exp) $display("FAIL %s addr %0d: got %h want %h", nm, a, o_rd_data, exp);
    else n_pass++;
  endtask

  task automatic run_expansion(input logic [127:0] key, input bit mid_start,
                               output int rk0, output int d0, output int r0, output int u0);
    bit ok;
    rk0 = rk_q.size(); d0 = done_cnt; r0 = rcon_q.size(); u0 = mon_unstable;
    tick();
    i_key_in = key;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_key_in = {$urandom, $urandom, $urandom, $urandom};
    n_checks++;
    if ({o_busy, o_err, o_rk_valid} !== 3'b101)
      $display("FAIL start_accept busy/err/rk_valid: got %b want 101", {o_busy, o_err, o_rk_valid});
    else n_pass++;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      if (mid_start && c == 4) begin
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL busy_mid_run: got %b want 1", o_busy);
        else n_pass++;
        i_start = 1'b1;
      end
      tick();
      i_start = 1'b0;
      if (done_cnt != d0) ok = 1'b1;
    end
    n_checks++;
    if (!ok) $display("FAIL expansion_done_timeout: got no done want done within 2000 cycles");
    else n_pass++;
  endtask

  task automatic check_sequence(input logic [127:0] key, input int rk0, input int d0,
                                input int r0, input int u0, input string tag);
    n_checks++;
    if (rk_q.size() - rk0 != NR + 1)
      $display("FAIL %s rk_count: got %0d want %0d", tag, rk_q.size() - rk0, NR + 1);
    else n_pass++;
    for (int i = 0; i <= NR; i++) if (rk0 + i < rk_q.size()) begin
      n_checks++;
      if (rk_q[rk0+i] !== {4'(i), ref_rk(key, i)})
        $display("FAIL %s rk[%0d]: got %h want %h", tag, i, rk_q[rk0+i], {4'(i), ref_rk(key, i)});
      else n_pass++;
    end
    n_checks++;
    if (rcon_q.size() - r0 != NR)
      $display("FAIL %s issue_count: got %0d want %0d", tag, rcon_q.size() - r0, NR);
    else n_pass++;
    for (int i = 0; i < NR; i++) if (r0 + i < rcon_q.size()) begin
      n_checks++;
      if ({rcon_q[r0+i], op_q[r0+i]} !== {rcon_ref(i+1), 24'h0, 1'b0})
        $display("FAIL %s rcon/opcode round %0d: got %h/%b want %h/0", tag, i + 1,
                 rcon_q[r0+i], op_q[r0+i], {rcon_ref(i+1), 24'h0});
      else n_pass++;
    end
    n_checks++;
    if ({done_cnt - d0, 31'd0, busy_at_done, o_err} !== {32'd1, 31'd0, 1'b0, 1'b0})
      $display("FAIL %s done_once/busy_at_done/err: got %0d/%b/%b want 1/0/0", tag,
               done_cnt - d0, busy_at_done, o_err);
    else n_pass++;
    n_checks++;
    if (mon_unstable != u0)
      $display("FAIL %s gen_inputs_stable: got %0d changes want 0", tag, mon_unstable - u0);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [425:0] v;
    reset = 1'b0;
    tick(); tick();
    v = {o_busy, o_done, o_err, o_rk_valid, o_rk_idx, o_rk_data, o_rd_data,
         o_gen_valid_in, o_gen_data_in, o_gen_rcon, o_gen_opcode};
    n_checks++;
    if (v !== '0) $display("FAIL reset_outputs: got %h want 0", v);
    else n_pass++;
    reset = 1'b1;
    tick();
    for (int a = 0; a <= NR; a += 5) rd_check(4'(a), '0, "reset_store");
  endtask

  task automatic test_fips();
    int rk0, d0, r0, u0;
    gen_lat = $urandom_range(0, 3);
    run_expansion(FIPS_KEY, 1'b0, rk0, d0, r0, u0);
    check_sequence(FIPS_KEY, rk0, d0, r0, u0, "fips");
    if (rk0 + NR < rk_q.size()) begin
      n_checks++;
      if (rk_q[rk0+1][127:0] !== FIPS_RK1) $display("FAIL fips_round1: got %h want %h", rk_q[rk0+1][127:0], FIPS_RK1);
      else n_pass++;
      n_checks++;
      if (rk_q[rk0+NR][127:0] !== FIPS_RK10) $display("FAIL fips_round10: got %h want %h", rk_q[rk0+NR][127:0], FIPS_RK10);
      else n_pass++;
    end
  endtask

  task automatic test_readback(input logic [127:0] key);
    for (int a = 0; a <= NR; a++) rd_check(4'(a), ref_rk(key, a), "readback");
    tick();
    n_checks++;
    if (o_rd_data !== ref_rk(key, NR)) $display("FAIL rd_hold: got %h want %h", o_rd_data, ref_rk(key, NR));
    else n_pass++;
    rd_check(4'd11, '0, "rd_out_of_range");
    rd_check(4'd3, ref_rk(key, 3), "readback_again");
    rd_check(4'd15, '0, "rd_out_of_range");
  endtask

  task automatic test_random_keys();
    int rk0, d0, r0, u0;
    logic [127:0] key;
    for (int k = 0; k < 3; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      gen_lat = $urandom_range(0, 4);
      run_expansion(key, 1'b0, rk0, d0, r0, u0);
      check_sequence(key, rk0, d0, r0, u0, "random");
    end
  endtask

  task automatic test_ignored_inputs();
    int rk0, d0, r0, u0;
    logic [127:0] key;
    key = {$urandom, $urandom, $urandom, $urandom};
    gen_lat = $urandom_range(1, 3);
    stray_mode = 1'b1;
    run_expansion(key, 1'b1, rk0, d0, r0, u0);
    stray_mode = 1'b0;
    check_sequence(key, rk0, d0, r0, u0, "ignored");
  endtask

  task automatic test_timeout();
    int rk0, d0, r0, u0;
    bit seen;
    logic [127:0] key;
    key = {$urandom, $urandom, $urandom, $urandom};
    gen_max_round = 3;
    gen_lat = $urandom_range(0, 3);
    rk0 = rk_q.size(); d0 = done_cnt;
    tick();
    i_key_in = key;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      tick();
      if (o_err) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL timeout_err: got err=0 want err=1 within 300 cycles");
    else n_pass++;
    n_checks++;
    if (cyc - issue_cyc != GEN_TIMEOUT)
      $display("FAIL timeout_latency: got %0d want %0d", cyc - issue_cyc, GEN_TIMEOUT);
    else n_pass++;
    n_checks++;
    if ({o_busy, done_cnt - d0, rk_q.size() - rk0} !== {1'b0, 32'd0, 32'd4})
      $display("FAIL timeout_state busy/done/rk: got %b/%0d/%0d want 0/0/4", o_busy, done_cnt - d0, rk_q.size() - rk0);
    else n_pass++;
    n_checks++;
    if (rcon_q[$] !== 32'h08000000) $display("FAIL timeout_round_rcon: got %h want 08000000", rcon_q[$]);
    else n_pass++;
    gen_max_round = NR;
    key = {$urandom, $urandom, $urandom, $urandom};
    run_expansion(key, 1'b0, rk0, d0, r0, u0);
    check_sequence(key, rk0, d0, r0, u0, "after_timeout");
  endtask

  task automatic test_reset_mid();
    int rk0, d0, r0, u0;
    bit found;
    logic [425:0] v;
    logic [127:0] key;
    key = {$urandom, $urandom, $urandom, $urandom};
    gen_lat = 3;
    rk0 = rk_q.size(); d0 = done_cnt;
    tick();
    i_key_in = key;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      tick();
      if (rk_q.size() - rk0 >= 5 && o_gen_valid_in) found = 1'b1;
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (!found || rcon_q[$] !== 32'h10000000)
      $display("FAIL reset_mid_round5: got found=%b rcon=%h want 1/10000000", found, rcon_q[$]);
    else n_pass++;
    v = {o_busy, o_done, o_err, o_rk_valid, o_rk_idx, o_rk_data, o_rd_data,
         o_gen_valid_in, o_gen_data_in, o_gen_rcon, o_gen_opcode};
    n_checks++;
    if (v !== '0) $display("FAIL reset_mid_outputs: got %h want 0", v);
    else n_pass++;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (done_cnt != d0) $display("FAIL reset_mid_no_done: got %0d want 0", done_cnt - d0);
    else n_pass++;
    for (int a = 0; a <= NR; a++) rd_check(4'(a), '0, "reset_mid_store");
    gen_lat = $urandom_range(0, 3);
    key = {$urandom, $urandom, $urandom, $urandom};
    run_expansion(key, 1'b0, rk0, d0, r0, u0);
    check_sequence(key, rk0, d0, r0, u0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_fips();
    test_readback(FIPS_KEY);
    test_random_keys();
    test_ignored_inputs();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
